// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory stage: access sizes, FSM states,
// byte-enable patterns and store-lane replication.
package mem_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R
  } mem_state_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // The reserved size encoding 2'b11 is handled as a word everywhere.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~off[0];
      default: return (off == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return BE_BYTE << off;
      SZ_HALF: return BE_HALF << off;
      default: return BE_WORD;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] replicate_store(input logic [1:0] size,
                                                      input logic [XLEN-1:0] data);
    case (size)
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half lane from a read word and sign- or
// zero-extends it to XLEN.
module load_align
  import mem_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [1:0]      size,
  input  logic            zext,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata[{addr, 3'b000} +: 8];
  assign half_v = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    case (size)
      SZ_BYTE: data = {{(XLEN-8){~zext & byte_v[7]}}, byte_v};
      SZ_HALF: data = {{(XLEN-16){~zext & half_v[15]}}, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: drives the req/gnt/rvalid data port, aligns loads and stores,
// and registers the writeback bundle. Define MEM_TIMEOUT_EN to add a watchdog.
module mem_stage #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  input  logic [4:0]      rd_i,
  input  logic            reg_write_i,
  output logic            stall_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            wb_valid_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic [4:0]      wb_rd_o,
  output logic            wb_reg_write_o,
  output logic            misalign_o
);
  import mem_pkg::*;

  mem_state_t      state_q, state_d;
  logic [XLEN-1:0] addr_q, wdata_q, load_data;
  logic [3:0]      be_q;
  logic            we_q;
  logic            mem_op, aligned, accept, completing, tmo_hit;

  if (TIMEOUT_CYCLES < 2) begin : g_tmo_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  // A read+write bundle is a store: mem_op covers both, we comes from mem_write_i.
  assign mem_op  = mem_read_i | mem_write_i;
  assign aligned = is_aligned(size_i, alu_result_i[1:0]);
  assign accept  = (state_q == IDLE) && valid_i && mem_op && aligned;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] tmo_cnt_q;

  assign tmo_hit = (state_q != IDLE) && (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || (state_d != state_q)) tmo_cnt_q <= '0;
    else if (state_q != IDLE)          tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns state_d and completing (no latches).
    state_d    = state_q;
    completing = 1'b0;
    case (state_q)
      IDLE:   if (accept) state_d = REQ;
      REQ:    if (dmem_gnt_i) begin
                state_d    = we_q ? IDLE : WAIT_R;
                completing = we_q;
              end
      // rvalid during REQ is ignored simply because only WAIT_R looks at it.
      WAIT_R: if (dmem_rvalid_i) begin
                state_d    = IDLE;
                completing = 1'b1;
              end
      default: state_d = IDLE;
    endcase
    if (tmo_hit) begin
      state_d    = IDLE;
      completing = 1'b1;
    end
  end

  assign stall_o = ~rst_i & (((state_q != IDLE) && !completing) || accept);

  load_align u_load_align (
    .rdata (dmem_rdata_i),
    .addr  (alu_result_i[1:0]),
    .size  (size_i),
    .zext  (unsigned_i),
    .data  (load_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      we_q           <= 1'b0;
      wb_valid_o     <= 1'b0;
      wb_data_o      <= '0;
      wb_rd_o        <= '0;
      wb_reg_write_o <= 1'b0;
      misalign_o     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q    <= state_d;
      wb_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      if (accept) begin
        addr_q  <= {alu_result_i[XLEN-1:2], 2'b00};
        be_q    <= byte_enables(size_i, alu_result_i[1:0]);
        we_q    <= mem_write_i;
        wdata_q <= replicate_store(size_i, store_data_i);
      end
      // Non-memory ops and misaligned accesses retire straight from IDLE.
      if ((state_q == IDLE) && valid_i && !accept) begin
        wb_valid_o     <= 1'b1;
        wb_rd_o        <= rd_i;
        wb_data_o      <= alu_result_i;
        wb_reg_write_o <= mem_op ? 1'b0 : reg_write_i;
        misalign_o     <= mem_op;
      end
      // Upstream still holds the bundle during the completing cycle.
      if (completing) begin
        wb_valid_o <= 1'b1;
        wb_rd_o    <= rd_i;
        if (tmo_hit) begin
          wb_data_o      <= '0;
          wb_reg_write_o <= 1'b0;
          misalign_o     <= 1'b1;
        end else if (state_q == WAIT_R) begin
          wb_data_o      <= load_data;
          wb_reg_write_o <= reg_write_i;
        end else begin
          wb_data_o      <= '0;
          wb_reg_write_o <= 1'b0;
        end
      end
    end
  end

  assign dmem_req_o   = (state_q == REQ);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected writebacks into a
// scoreboard, an independent monitor pops and compares on each wb_valid_o.
module tb_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] alu_result_i, store_data_i;
  logic        mem_read_i, mem_write_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [4:0]  rd_i;
  logic        reg_write_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic        wb_reg_write_o, misalign_o;

  mem_stage dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .valid_i        (valid_i),
    .alu_result_i   (alu_result_i),
    .store_data_i   (store_data_i),
    .mem_read_i     (mem_read_i),
    .mem_write_i    (mem_write_i),
    .size_i         (size_i),
    .unsigned_i     (unsigned_i),
    .rd_i           (rd_i),
    .reg_write_i    (reg_write_i),
    .stall_o        (stall_o),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_be_o      (dmem_be_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_gnt_i     (dmem_gnt_i),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .dmem_rdata_i   (dmem_rdata_i),
    .wb_valid_o     (wb_valid_o),
    .wb_data_o      (wb_data_o),
    .wb_rd_o        (wb_rd_o),
    .wb_reg_write_o (wb_reg_write_o),
    .misalign_o     (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        regw;
    logic        mis;
    logic        chk_data;
    int          at_cyc;
  } wb_exp_t;

  wb_exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every writeback pulse must match the oldest expectation, in its cycle.
  always @(negedge clk_i) begin
    wb_exp_t e;
    if (wb_valid_o) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wb_unexpected: got wb_valid_o=1 at cycle %0d, expected no writeback", cyc);
      end else begin
        e = sb.pop_front();
        check("wb_cycle", cyc, e.at_cyc);
        check("wb_rd", {27'b0, wb_rd_o}, {27'b0, e.rd});
        check("wb_reg_write", {31'b0, wb_reg_write_o}, {31'b0, e.regw});
        check("wb_misalign", {31'b0, misalign_o}, {31'b0, e.mis});
        if (e.chk_data) check("wb_data", wb_data_o, e.data);
        if (e.mis) check("no_req_on_misalign", {31'b0, dmem_req_o}, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] data, input logic [4:0] rd, input logic regw,
                          input logic mis, input logic chk_data);
    wb_exp_t e;
    e.data = data; e.rd = rd; e.regw = regw; e.mis = mis; e.chk_data = chk_data; e.at_cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic set_bundle(input logic [31:0] alu, input logic [31:0] sd, input logic rd_f,
                            input logic wr_f, input logic [1:0] sz, input logic uns,
                            input logic [4:0] rdx, input logic regw);
    valid_i = 1'b1; alu_result_i = alu; store_data_i = sd; mem_read_i = rd_f;
    mem_write_i = wr_f; size_i = sz; unsigned_i = uns; rd_i = rdx; reg_write_i = regw;
  endtask

  task automatic check_req(input string name, input logic [31:0] ea, input logic [3:0] ebe,
                           input logic ewe, input logic [31:0] ewd);
    check({name, "_req"}, {31'b0, dmem_req_o}, 32'd1);
    check({name, "_addr"}, dmem_addr_o, ea);
    check({name, "_be"}, {28'b0, dmem_be_o}, {28'b0, ebe});
    check({name, "_we"}, {31'b0, dmem_we_o}, {31'b0, ewe});
    if (ewe) check({name, "_wdata"}, dmem_wdata_o, ewd);
  endtask

  // Issues one bundle, plays the memory side, then pushes the expected writeback.
  task automatic run_op(input string name, input logic [31:0] alu, input logic [31:0] sd,
                        input logic rd_f, input logic wr_f, input logic [1:0] sz,
                        input logic uns, input logic [4:0] rdx, input logic regw,
                        input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                        input logic exp_mem, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_wb, input logic exp_mis,
                        input logic exp_regw, input logic chk_data);
    set_bundle(alu, sd, rd_f, wr_f, sz, uns, rdx, regw);
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    @(negedge clk_i);
    check({name, "_stall_accept"}, {31'b0, stall_o}, {31'b0, exp_mem});
    check({name, "_noreq_accept"}, {31'b0, dmem_req_o}, 32'd0);
    step();
    if (exp_mem) begin
      for (int i = 0; i < gnt_dly; i++) begin
        @(negedge clk_i);
        check({name, "_stall_req"}, {31'b0, stall_o}, 32'd1);
        check_req(name, exp_addr, exp_be, wr_f, exp_wdata);
        step();
      end
      dmem_gnt_i = 1'b1;
      if (!wr_f) begin
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hDEAD_BEEF;
      end
      @(negedge clk_i);
      check({name, "_stall_gnt"}, {31'b0, stall_o}, {31'b0, ~wr_f});
      check_req(name, exp_addr, exp_be, wr_f, exp_wdata);
      step();
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
      if (!wr_f) begin
        for (int i = 1; i < rv_dly; i++) begin
          @(negedge clk_i);
          check({name, "_stall_wait"}, {31'b0, stall_o}, 32'd1);
          check({name, "_req_dropped"}, {31'b0, dmem_req_o}, 32'd0);
          step();
        end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
        @(negedge clk_i);
        check({name, "_stall_rvalid"}, {31'b0, stall_o}, 32'd0);
        step();
        dmem_rvalid_i = 1'b0;
      end
    end
    valid_i = 1'b0;
    push_exp(exp_wb, rdx, exp_regw, exp_mis, chk_data);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_stall"}, {31'b0, stall_o}, 32'd0);
    check({name, "_req"}, {31'b0, dmem_req_o}, 32'd0);
    check({name, "_we"}, {31'b0, dmem_we_o}, 32'd0);
    check({name, "_addr"}, dmem_addr_o, 32'd0);
    check({name, "_be"}, {28'b0, dmem_be_o}, 32'd0);
    check({name, "_wdata"}, dmem_wdata_o, 32'd0);
    check({name, "_wb_valid"}, {31'b0, wb_valid_o}, 32'd0);
    check({name, "_wb_data"}, wb_data_o, 32'd0);
    check({name, "_wb_rd"}, {27'b0, wb_rd_o}, 32'd0);
    check({name, "_wb_reg_write"}, {31'b0, wb_reg_write_o}, 32'd0);
    check({name, "_misalign"}, {31'b0, misalign_o}, 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; alu_result_i = '0; store_data_i = '0;
    mem_read_i = 1'b0; mem_write_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0;
    rd_i = '0; reg_write_i = 1'b0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    repeat (2) step();
    @(negedge clk_i);
    check_all_zero("reset");
    step();
    rst_i = 1'b0;

    //     name           alu           sd            rd wr sz    un rd  rw gnt rv rdata         mem addr          be       wdata         wb            mis rw chk
    run_op("alu_pass",    32'h1234_5678, 32'h0,        0, 0, 2'b10, 0, 5, 1, 0, 0, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h1234_5678, 0, 1, 1);
    run_op("sb_1003",     32'h0000_1003, 32'h0000_00A5, 0, 1, 2'b00, 0, 6, 1, 3, 0, 32'h0,        1, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 32'h0,        0, 0, 0);
    step();
    run_op("lb_signed",   32'h0000_3002, 32'h0,        1, 0, 2'b00, 0, 7, 1, 0, 2, 32'h0080_0000, 1, 32'h0000_3000, 4'b0100, 32'h0,        32'hFFFF_FF80, 0, 1, 1);
    run_op("lbu",         32'h0000_3002, 32'h0,        1, 0, 2'b00, 1, 7, 1, 0, 2, 32'h0080_0000, 1, 32'h0000_3000, 4'b0100, 32'h0,        32'h0000_0080, 0, 1, 1);
    run_op("lw_misalign", 32'h0000_2002, 32'h0,        1, 0, 2'b10, 0, 8, 1, 0, 0, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0, 0);
    run_op("sh_4002",     32'h0000_4002, 32'h1234_BEEF, 0, 1, 2'b01, 0, 9, 0, 0, 0, 32'h0,        1, 32'h0000_4000, 4'b1100, 32'hBEEF_BEEF, 32'h0,        0, 0, 0);
    run_op("lh_hi",       32'h0000_4002, 32'h0,        1, 0, 2'b01, 0, 10, 1, 1, 1, 32'h8001_7FFF, 1, 32'h0000_4000, 4'b1100, 32'h0,        32'hFFFF_8001, 0, 1, 1);
    step();
    run_op("lhu_hi",      32'h0000_4002, 32'h0,        1, 0, 2'b01, 1, 11, 1, 0, 1, 32'h8001_7FFF, 1, 32'h0000_4000, 4'b1100, 32'h0,        32'h0000_8001, 0, 1, 1);
    run_op("lh_lo",       32'h0000_4000, 32'h0,        1, 0, 2'b01, 0, 12, 1, 0, 1, 32'h8001_7FFF, 1, 32'h0000_4000, 4'b0011, 32'h0,        32'h0000_7FFF, 0, 1, 1);
    run_op("sw_5000",     32'h0000_5000, 32'hCAFE_BABE, 0, 1, 2'b10, 0, 13, 0, 2, 0, 32'h0,        1, 32'h0000_5000, 4'b1111, 32'hCAFE_BABE, 32'h0,        0, 0, 0);
    run_op("lw_5004",     32'h0000_5004, 32'h0,        1, 0, 2'b10, 0, 14, 1, 1, 3, 32'h1234_5678, 1, 32'h0000_5004, 4'b1111, 32'h0,        32'h1234_5678, 0, 1, 1);
    run_op("rw_both",     32'h0000_6001, 32'h0000_0077, 1, 1, 2'b00, 0, 15, 1, 0, 0, 32'h0,        1, 32'h0000_6000, 4'b0010, 32'h7777_7777, 32'h0,        0, 0, 0);
    run_op("sh_misalign", 32'h0000_7001, 32'h0000_1111, 0, 1, 2'b01, 0, 16, 0, 0, 0, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0, 0);
    run_op("lb_off1",     32'h0000_1001, 32'h0,        1, 0, 2'b00, 0, 17, 0, 0, 1, 32'h1234_7F56, 1, 32'h0000_1000, 4'b0010, 32'h0,        32'h0000_007F, 0, 0, 1);
    run_op("alu_noreg",   32'hDEAD_BEEF, 32'h0,        0, 0, 2'b10, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'hDEAD_BEEF, 0, 0, 1);

    // Reset while a load sits in WAIT_R: the access is dropped with no writeback.
    set_bundle(32'h0000_9000, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd3, 1'b1);
    step();
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    @(negedge clk_i);
    check("rst_in_wait_stall", {31'b0, stall_o}, 32'd1);
    check("rst_in_wait_noreq", {31'b0, dmem_req_o}, 32'd0);
    step();
    rst_i = 1'b1; valid_i = 1'b0;
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check_all_zero("rst_mid");
    step();
    run_op("lw_after_rst", 32'h0000_9000, 32'h0,       1, 0, 2'b10, 0, 3, 1, 0, 1, 32'hA5A5_0F0F, 1, 32'h0000_9000, 4'b1111, 32'h0,        32'hA5A5_0F0F, 0, 1, 1);

`ifdef MEM_TIMEOUT_EN
    begin
      int  n        = 0;
      logic released = 1'b0;
      set_bundle(32'h0000_A000, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd20, 1'b1);
      dmem_gnt_i = 1'b0;
      step();
      for (int i = 0; i < 300 && !released; i++) begin
        @(negedge clk_i);
        n++;
        if (!stall_o) released = 1'b1;
        else step();
      end
      check("tmo_released", {31'b0, released}, 32'd1);
      check("tmo_req_cycles", n, 32'd256);
      step();
      valid_i = 1'b0;
      push_exp(32'h0, 5'd20, 1'b0, 1'b1, 1'b0);
    end
`endif

    repeat (4) step();
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
